// File: rtl/irq_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register map,
// ACTIVE register layout and a lane-mask helper for NIRQ < 32.
package irq_ctrl_pkg;

    // Register select values (bus_address[2:0])
    localparam logic [2:0] IRQ_PEND = 3'd0;
    localparam logic [2:0] IRQ_EN   = 3'd1;
    localparam logic [2:0] IRQ_EDGE = 3'd2;
    localparam logic [2:0] IRQ_ACT  = 3'd3;
    localparam logic [2:0] IRQ_SET  = 3'd4;
    localparam logic [2:0] IRQ_RAW  = 3'd5;

    // ACTIVE register: valid flag position, vector in [4:0]
    localparam int ACT_VALID_BIT = 31;
    localparam int IRQ_IDX_W     = 5;

    // Bits [n-1:0] set; lanes at or above n are unimplemented.
    function automatic logic [31:0] irq_lane_mask(input int n);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (i < n);
        end
        return m;
    endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc32.sv
// prio_enc32: 32-bit lowest-index priority encoder.
// Ports: i_vec request vector; o_valid any bit set; o_idx lowest set index (0 if none).
module prio_enc32
    import irq_ctrl_pkg::*;
(
    input  logic [31:0]          i_vec,
    output logic                 o_valid,
    output logic [IRQ_IDX_W-1:0] o_idx
);

    always_comb begin
        o_idx = '0;
        // Scan downward so the lowest set index is the last one written.
        for (int i = 31; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = IRQ_IDX_W'(i);
            end
        end
    end

    assign o_valid = |i_vec;

endmodule

// File: rtl/irq_ctrl.sv
// irq_ctrl: bus-mapped interrupt controller with per-source edge/level
// pending bits, enable mask and fixed priority (bit 0 highest).
// Ports: clk, reset (async, active-high); cs/wen/addr/din/dout register bus;
//        irqs_in sources (bit0 = timer); irq request and irq_num vector out.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NIRQ  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cs,
    input  logic             wen,
    input  logic [2:0]       addr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    input  logic [31:0]      irqs_in,
    output logic             irq,
    output logic [4:0]       irq_num
);

    localparam logic [31:0] LMASK = irq_lane_mask(NIRQ);

    logic [31:0] r_pend;
    logic [31:0] r_en;
    logic [31:0] r_edge;
    logic [31:0] r_prev;

    logic [31:0] w_din;
    logic [31:0] w_irqs;
    logic        w_wr;
    logic        w_wr_pend;
    logic        w_wr_en;
    logic        w_wr_edge;
    logic        w_wr_act;
    logic        w_wr_set;
    logic [31:0] w_act;
    logic        w_valid;
    logic [4:0]  w_idx;
    logic [31:0] w_rise;
    logic [31:0] w_set;
    logic [31:0] w_ack;
    logic [31:0] w_clr;
    logic [31:0] w_pend_edge;
    logic [31:0] w_pend_nxt;
    logic [31:0] w_rdata;

    assign w_din  = din;
    assign w_irqs = irqs_in & LMASK;

    // Bus write decode
    assign w_wr      = cs & wen;
    assign w_wr_pend = w_wr && (addr == IRQ_PEND);
    assign w_wr_en   = w_wr && (addr == IRQ_EN);
    assign w_wr_edge = w_wr && (addr == IRQ_EDGE);
    assign w_wr_act  = w_wr && (addr == IRQ_ACT);
    assign w_wr_set  = w_wr && (addr == IRQ_SET);

    // Active vector and priority resolution
    assign w_act = r_pend & r_en & LMASK;

    prio_enc32 u_prio (
        .i_vec   (w_act),
        .o_valid (w_valid),
        .o_idx   (w_idx)
    );

    assign irq     = w_valid;
    assign irq_num = w_idx;

    // Pending update: set wins over clear for edge lanes;
    // level lanes simply mirror the input.
    assign w_rise = w_irqs & ~r_prev;
    assign w_set  = w_rise | (w_wr_set ? w_din : 32'd0);
    assign w_ack  = (w_wr_act && w_valid) ? (32'd1 << w_idx) : 32'd0;
    assign w_clr  = (w_wr_pend ? w_din : 32'd0) | w_ack;

    assign w_pend_edge = (r_pend & ~w_clr) | w_set;
    assign w_pend_nxt  = ((r_edge & w_pend_edge) |
                          (~r_edge & w_irqs)) & LMASK;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend <= '0;
            r_en   <= '0;
            r_edge <= LMASK;
            r_prev <= '0;
        end else begin
            r_pend <= w_pend_nxt;
            r_prev <= w_irqs;
            if (w_wr_en) begin
                r_en <= w_din & LMASK;
            end
            if (w_wr_edge) begin
                r_edge <= w_din & LMASK;
            end
        end
    end

    // Combinational read mux
    always_comb begin
        w_rdata = '0;
        if (cs) begin
            case (addr)
                IRQ_PEND: w_rdata = r_pend;
                IRQ_EN:   w_rdata = r_en;
                IRQ_EDGE: w_rdata = r_edge;
                IRQ_ACT: begin
                    w_rdata[ACT_VALID_BIT] = w_valid;
                    w_rdata[4:0]           = w_idx;
                end
                IRQ_RAW:  w_rdata = w_irqs;
                default:  w_rdata = '0;
            endcase
        end
    end

    assign dout = w_rdata;

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed sequences, a vector table
// and a randomized run against a per-source behavioural model.
module tb_irq_ctrl;

    logic        clk;
    logic        reset;
    logic        cs;
    logic        wen;
    logic [2:0]  addr;
    logic [31:0] din;
    logic [31:0] dout;
    logic [31:0] irqs_in;
    logic        irq;
    logic [4:0]  irq_num;

    int tests;
    int fails;

    irq_ctrl #(.WIDTH(32), .NIRQ(32)) dut (
        .clk     (clk),
        .reset   (reset),
        .cs      (cs),
        .wen     (wen),
        .addr    (addr),
        .din     (din),
        .dout    (dout),
        .irqs_in (irqs_in),
        .irq     (irq),
        .irq_num (irq_num)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] irqs;
        logic [31:0] en;
        logic        exp_irq;
        logic [4:0]  exp_num;
        logic [31:0] exp_pend;
    } vec_t;

    vec_t vecs[8];

    // Behavioural model state, one entry per source
    bit m_pend[32];
    bit m_en[32];
    bit m_edge[32];
    bit m_prev[32];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wen = 1'b1; addr = a; din = d;
        tick();
        cs = 1'b0; wen = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        cs = 1'b1; wen = 1'b0; addr = a;
        #1;
        d = dout;
        cs = 1'b0;
    endtask

    function automatic int model_num();
        for (int i = 0; i < 32; i++) begin
            if (m_pend[i] && m_en[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_pend[i] = 0; m_en[i] = 0; m_edge[i] = 1; m_prev[i] = 0;
        end
    endtask

    // One clock of the model, given the inputs present before the edge.
    task automatic model_step(input logic [31:0] ni, input bit w,
                              input logic [2:0] a, input logic [31:0] d);
        int  n;
        bit  s;
        bit  c;
        n = model_num();
        for (int i = 0; i < 32; i++) begin
            if (m_edge[i]) begin
                s = (ni[i] && !m_prev[i]) || (w && a == 3'd4 && d[i]);
                c = (w && a == 3'd0 && d[i]) || (w && a == 3'd3 && n == i);
                if (s) m_pend[i] = 1;
                else if (c) m_pend[i] = 0;
            end else begin
                m_pend[i] = ni[i];
            end
        end
        for (int i = 0; i < 32; i++) begin
            if (w && a == 3'd1) m_en[i] = d[i];
            if (w && a == 3'd2) m_edge[i] = d[i];
            m_prev[i] = ni[i];
        end
    endtask

    function automatic logic [31:0] model_pend();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] ni;
        logic [31:0] d;
        logic [2:0]  a;
        int          op;
        int          n;
        bit          w;

        tests = 0; fails = 0;
        reset = 1'b1; cs = 1'b0; wen = 1'b0; addr = '0; din = '0;
        irqs_in = '0;

        vecs[0] = '{32'h0000_0100, 32'hFFFF_FFFF, 1'b1, 5'd8,  32'h0000_0100};
        vecs[1] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 5'd31, 32'h8000_0000};
        vecs[2] = '{32'h0000_00F0, 32'h0000_000F, 1'b0, 5'd0,  32'h0000_00F0};
        vecs[3] = '{32'h0000_00F0, 32'h0000_0030, 1'b1, 5'd4,  32'h0000_00F0};
        vecs[4] = '{32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 5'd0,  32'h0000_0000};
        vecs[5] = '{32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 5'd31, 32'hFFFF_FFFF};
        vecs[6] = '{32'h0006_0000, 32'h0004_0000, 1'b1, 5'd18, 32'h0006_0000};
        vecs[7] = '{32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 5'd0,  32'h0000_0001};

        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        chk("rst_irq", {31'd0, irq}, 32'd0);
        chk("rst_num", {27'd0, irq_num}, 32'd0);
        rd(3'd0, r); chk("rst_pend", r, 32'd0);
        rd(3'd1, r); chk("rst_en", r, 32'd0);
        rd(3'd2, r); chk("rst_edge", r, 32'hFFFF_FFFF);
        rd(3'd3, r); chk("rst_act", r, 32'd0);

        // Reset mid-operation
        irqs_in = 32'h5;
        tick();
        wr(3'd1, 32'h5);
        chk("mid_irq_pre", {31'd0, irq}, 32'd1);
        rd(3'd0, r); chk("mid_pend_pre", r, 32'h5);
        #3;
        reset = 1'b1;
        irqs_in = '0;
        #1;
        chk("mid_irq", {31'd0, irq}, 32'd0);
        rd(3'd0, r); chk("mid_pend", r, 32'd0);
        rd(3'd1, r); chk("mid_en", r, 32'd0);
        tick();
        reset = 1'b0;
        rd(3'd2, r); chk("mid_edge", r, 32'hFFFF_FFFF);

        // Timer edge and acknowledge
        wr(3'd1, 32'h1);
        irqs_in = 32'h1;
        tick();
        chk("tmr_irq", {31'd0, irq}, 32'd1);
        chk("tmr_num", {27'd0, irq_num}, 32'd0);
        rd(3'd3, r); chk("tmr_act", r, 32'h8000_0000);
        rd(3'd5, r); chk("tmr_raw", r, 32'h1);
        wr(3'd3, 32'h0);
        chk("tmr_ack_irq", {31'd0, irq}, 32'd0);
        rd(3'd0, r); chk("tmr_ack_pend", r, 32'd0);
        tick();
        chk("tmr_hold_irq", {31'd0, irq}, 32'd0);
        irqs_in = '0;
        tick();

        // Priority
        wr(3'd1, 32'hFFFF_FFFF);
        irqs_in = 32'h88;
        tick();
        chk("pri_num3", {27'd0, irq_num}, 32'd3);
        wr(3'd3, 32'h0);
        chk("pri_irq7", {31'd0, irq}, 32'd1);
        chk("pri_num7", {27'd0, irq_num}, 32'd7);
        wr(3'd3, 32'h0);
        chk("pri_none", {31'd0, irq}, 32'd0);
        irqs_in = '0;
        tick();

        // Set beats clear
        irqs_in = 32'h4;
        wr(3'd0, 32'h4);
        rd(3'd0, r); chk("sbc_pend", r, 32'h4);
        wr(3'd0, 32'h4);
        rd(3'd0, r); chk("sbc_clr", r, 32'h0);
        wr(3'd4, 32'h4);
        rd(3'd0, r); chk("sbc_set", r, 32'h4);
        wr(3'd0, 32'hFFFF_FFFF);
        irqs_in = '0;
        tick();

        // Level mode
        wr(3'd2, 32'h0);
        wr(3'd1, 32'h2);
        irqs_in = 32'h2;
        tick();
        chk("lvl_irq", {31'd0, irq}, 32'd1);
        chk("lvl_num", {27'd0, irq_num}, 32'd1);
        wr(3'd0, 32'h2);
        rd(3'd0, r); chk("lvl_noclr", r, 32'h2);
        irqs_in = '0;
        tick();
        rd(3'd0, r); chk("lvl_drop_pend", r, 32'h0);
        chk("lvl_drop_irq", {31'd0, irq}, 32'd0);
        wr(3'd2, 32'hFFFF_FFFF);

        // Masking
        wr(3'd1, 32'h0);
        wr(3'd4, 32'h10);
        chk("msk_irq", {31'd0, irq}, 32'd0);
        rd(3'd0, r); chk("msk_pend", r, 32'h10);
        wr(3'd1, 32'h10);
        chk("msk_irq_en", {31'd0, irq}, 32'd1);
        chk("msk_num", {27'd0, irq_num}, 32'd4);
        rd(3'd6, r); chk("msk_addr6", r, 32'h0);
        rd(3'd7, r); chk("msk_addr7", r, 32'h0);
        rd(3'd4, r); chk("msk_addr4", r, 32'h0);

        // Write with cs low is ignored
        cs = 1'b0; wen = 1'b1; addr = 3'd1; din = 32'hFF;
        tick();
        wen = 1'b0;
        rd(3'd1, r); chk("nocs_en", r, 32'h10);
        wr(3'd0, 32'hFFFF_FFFF);

        // Vector table
        foreach (vecs[k]) begin
            irqs_in = '0;
            tick();
            wr(3'd0, 32'hFFFF_FFFF);
            wr(3'd1, vecs[k].en);
            irqs_in = vecs[k].irqs;
            tick();
            chk($sformatf("vec%0d_irq", k), {31'd0, irq},
                {31'd0, vecs[k].exp_irq});
            chk($sformatf("vec%0d_num", k), {27'd0, irq_num},
                {27'd0, vecs[k].exp_num});
            rd(3'd0, r);
            chk($sformatf("vec%0d_pend", k), r, vecs[k].exp_pend);
            rd(3'd5, r);
            chk($sformatf("vec%0d_raw", k), r, vecs[k].irqs);
        end

        // Randomized run against the model
        irqs_in = '0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_reset();
        for (int c = 0; c < 500; c++) begin
            ni = irqs_in ^ ($urandom & $urandom & $urandom);
            op = $urandom_range(0, 9);
            a  = 3'($urandom_range(0, 7));
            if (a == 3'd2) d = ~($urandom & $urandom & $urandom);
            else d = $urandom & $urandom;
            irqs_in = ni;
            cs  = (op >= 5 && op <= 8);
            wen = (op >= 5);
            addr = a;
            din  = d;
            w = (op >= 5 && op <= 8);
            model_step(ni, w, a, d);
            @(posedge clk);
            #1;
            cs = 1'b0; wen = 1'b0;
            n = model_num();
            chk("rnd_irq", {31'd0, irq}, {31'd0, (n >= 0)});
            chk("rnd_num", {27'd0, irq_num}, (n >= 0) ? n : 0);
            rd(3'd0, r);
            chk("rnd_pend", r, model_pend());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
